// File: rtl/wwm_btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// wwm_btn_conditioner_if
//   Bundles the raw push-button levels and the three conditioned button
//   vectors that leave the conditioner towards wwm_sm.
//
//   btn_in   : raw asynchronous button levels, active-high (driven by master)
//   btn_db   : debounced level per lane                     (driven by slave)
//   btn_scen : one-clock pulse per accepted press           (driven by slave)
//   btn_mcen : press pulse plus optional auto-repeat pulses (driven by slave)
//
//   master : the board / testbench side that owns the raw buttons
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface wwm_btn_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_scen;
    logic [N_BTN-1:0] btn_mcen;

    modport master (
        output btn_in,
        input  btn_db,
        input  btn_scen,
        input  btn_mcen
    );

    modport slave (
        input  btn_in,
        output btn_db,
        output btn_scen,
        output btn_mcen
    );
endinterface

// File: rtl/wwm_btn_conditioner.sv
// -----------------------------------------------------------------------------
// wwm_btn_conditioner
//   Input conditioning between the raw Nexys4 push-buttons and wwm_sm. Each
//   lane runs a 2-FF synchronizer followed by a counter-based debounce FSM
//   (INI -> WQ -> SCEN_ST -> HOLD <-> WFR -> INI), so one physical press
//   yields exactly one single-clock press pulse.
//
//   Ports:
//     clk   : board clock
//     Reset : synchronous, active-high reset
//     bus   : wwm_btn_conditioner_if.slave (btn_in in; btn_db/btn_scen/btn_mcen out)
//
//   Optional feature (macro WWM_BTN_REPEAT_EN):
//     defined   -> btn_mcen also pulses every RPT_CYCLES clocks while a lane is
//                  held (HOLD or WFR), counting from the SCEN_ST cycle.
//     undefined -> the repeat counter is absent and btn_mcen equals btn_scen.
// -----------------------------------------------------------------------------
module wwm_btn_conditioner #(
    parameter int N_BTN      = 3,
    parameter int DB_CYCLES  = 1000000,
    parameter int RPT_CYCLES = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic                  clk,
    input  logic                  Reset,
    wwm_btn_conditioner_if.slave  bus
);

    typedef enum logic [2:0] {
        INI     = 3'd0,
        WQ      = 3'd1,
        SCEN_ST = 3'd2,
        HOLD    = 3'd3,
        WFR     = 3'd4
    } lane_state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // Reject illegal configurations at elaboration rather than misbehaving.
    if (DB_CYCLES < 2 || RPT_CYCLES < 2 ||
        (longint'(1) << CNT_W) <= longint'(DB_CYCLES) ||
        (longint'(1) << CNT_W) <= longint'(RPT_CYCLES)) begin : g_param_err
        $error("wwm_btn_conditioner: illegal DB_CYCLES/RPT_CYCLES/CNT_W");
    end

    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    lane_state_e      state_q [N_BTN];
    lane_state_e      state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] db_q,   db_d;
    logic [N_BTN-1:0] scen_q, scen_d;

`ifdef WWM_BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CYCLES - 1);

    logic [CNT_W-1:0] rcnt_q [N_BTN];
    logic [CNT_W-1:0] rcnt_d [N_BTN];
    logic [N_BTN-1:0] mcen_q, mcen_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        s1_d   = bus.btn_in;
        s2_d   = s1_q;
        db_d   = '0;
        scen_d = '0;
`ifdef WWM_BTN_REPEAT_EN
        mcen_d = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            unique case (state_q[i])
                INI: begin
                    cnt_d[i] = '0;
                    if (s2_q[i]) state_d[i] = WQ;
                end
                WQ: begin
                    if (!s2_q[i]) begin
                        state_d[i] = INI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = SCEN_ST;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                SCEN_ST: begin
                    state_d[i] = HOLD;
                    cnt_d[i]   = '0;
                end
                HOLD: begin
                    cnt_d[i] = '0;
                    if (!s2_q[i]) state_d[i] = WFR;
                end
                WFR: begin
                    if (s2_q[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = INI;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = INI;
                    cnt_d[i]   = '0;
                end
            endcase

            // Outputs are decoded from the next state and registered, so they
            // change on the same edge the lane enters its new state.
            db_d[i]   = (state_d[i] == SCEN_ST) || (state_d[i] == HOLD) ||
                        (state_d[i] == WFR);
            scen_d[i] = (state_d[i] == SCEN_ST);

`ifdef WWM_BTN_REPEAT_EN
            // rcnt runs while the lane is held, including WFR bounce, and
            // restarts from 0 on entry to HOLD from SCEN_ST. The pulse is
            // registered from rcnt_d so it coincides with rcnt==RPT_CYCLES-1.
            if ((state_q[i] == HOLD || state_q[i] == WFR) && state_d[i] != INI)
                rcnt_d[i] = (rcnt_q[i] == RPT_LAST) ? '0 : rcnt_q[i] + 1'b1;
            else
                rcnt_d[i] = '0;
            mcen_d[i] = scen_d[i] ||
                        ((state_d[i] == HOLD || state_d[i] == WFR) &&
                         rcnt_d[i] == RPT_LAST);
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole datapath, counters included, is cleared by reset so
        // a press in progress is aborted and must be fully re-debounced.
        if (Reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            scen_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= INI;
                cnt_q[i]   <= '0;
            end
`ifdef WWM_BTN_REPEAT_EN
            mcen_q <= '0;
            for (int i = 0; i < N_BTN; i++) rcnt_q[i] <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values, which is what makes s1 -> s2 a true two-stage pipeline.
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            scen_q <= scen_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef WWM_BTN_REPEAT_EN
            mcen_q <= mcen_d;
            for (int i = 0; i < N_BTN; i++) rcnt_q[i] <= rcnt_d[i];
`endif
        end
    end

    assign bus.btn_db   = db_q;
    assign bus.btn_scen = scen_q;
`ifdef WWM_BTN_REPEAT_EN
    assign bus.btn_mcen = mcen_q;
`else
    assign bus.btn_mcen = scen_q;
`endif

endmodule

// File: tb/tb_wwm_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_wwm_btn_conditioner
//   Directed self-checking bench for wwm_btn_conditioner with DB_CYCLES=4,
//   RPT_CYCLES=8, N_BTN=3. Each step drives btn_in, lets one rising edge pass,
//   and compares btn_db/btn_scen/btn_mcen 1 ns later against hand-derived
//   values. Step numbers count edges; a level sampled at edge E produces its
//   press pulse right after edge E+6 and its release right after edge E+6.
//   Expected repeat pulses depend on WWM_BTN_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_wwm_btn_conditioner;

    localparam int N_BTN      = 3;
    localparam int DB_CYCLES  = 4;
    localparam int RPT_CYCLES = 8;
    localparam int CNT_W      = 4;
`ifdef WWM_BTN_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    wwm_btn_conditioner_if #(.N_BTN(N_BTN)) bus ();

    wwm_btn_conditioner #(
        .N_BTN      (N_BTN),
        .DB_CYCLES  (DB_CYCLES),
        .RPT_CYCLES (RPT_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one input vector, let one edge pass, then compare all outputs.
    task automatic step_chk(input string tag, input logic [2:0] in,
                            input logic [2:0] db, input logic [2:0] scen,
                            input logic [2:0] mcen);
        bus.btn_in = in;
        @(posedge clk);
        #1;
        check({tag, " db"},   bus.btn_db,   db);
        check({tag, " scen"}, bus.btn_scen, scen);
        check({tag, " mcen"}, bus.btn_mcen, mcen);
    endtask

    // Release every lane and check the db fall after 6 edges; mcen_at marks
    // an expected repeat pulse at that release step (0 = none).
    task automatic release_chk(input string tag, input logic [2:0] lanes, input int mcen_at);
        for (int r = 1; r <= 8; r++)
            step_chk($sformatf("%s rel%0d", tag, r), 3'b000,
                     (r < 7) ? lanes : 3'b000, 3'b000,
                     (RPT && r == mcen_at) ? lanes : 3'b000);
    endtask

    initial begin
        logic [2:0] p;

        // 1) Reset held 3 edges with all buttons pressed, then all lanes
        //    qualify together.
        Reset = 1'b1;
        for (int k = 1; k <= 3; k++)
            step_chk($sformatf("t1 rst%0d", k), 3'b111, 3'b000, 3'b000, 3'b000);
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            p = (k == 7) ? 3'b111 : 3'b000;
            step_chk($sformatf("t1 k%0d", k), 3'b111,
                     (k >= 7) ? 3'b111 : 3'b000, p, p);
        end
        release_chk("t1", 3'b111, 0);

        // 2) Lane 0 high for only 3 edges: rejected as a glitch.
        for (int k = 1; k <= 9; k++)
            step_chk($sformatf("t2 k%0d", k), (k <= 3) ? 3'b001 : 3'b000,
                     3'b000, 3'b000, 3'b000);

        // 3) Lane 1 bounces 1010 1100 then holds for 20 edges. The last
        //    rising sample is step 9, so the press pulse follows step 15;
        //    a repeat pulse follows step 23 and again at release step 3.
        for (int s = 1; s <= 28; s++) begin
            logic [7:0] bounce;
            bounce = 8'b1010_1100;
            p = (s == 15) ? 3'b010 : 3'b000;
            step_chk($sformatf("t3 s%0d", s),
                     (s <= 8) ? {1'b0, bounce[8-s], 1'b0} : 3'b010,
                     (s >= 15) ? 3'b010 : 3'b000, p,
                     (s == 15 || (RPT && s == 23)) ? 3'b010 : 3'b000);
        end
        release_chk("t3", 3'b010, 3);

        // 4) Lane 0 held with a 2-edge low glitch in HOLD: no db drop and
        //    no second press pulse; repeat timing is unaffected.
        for (int s = 1; s <= 24; s++) begin
            p = (s == 7) ? 3'b001 : 3'b000;
            step_chk($sformatf("t4 s%0d", s),
                     (s == 11 || s == 12) ? 3'b000 : 3'b001,
                     (s >= 7) ? 3'b001 : 3'b000, p,
                     (s == 7 || (RPT && (s == 15 || s == 23))) ? 3'b001 : 3'b000);
        end
        release_chk("t4", 3'b001, 0);

        // 5) Lane 2 held 30 edges: press pulse once at step 7, repeat pulses
        //    at 15, 23 and 31 (release step 1, still held after the sync).
        for (int s = 1; s <= 30; s++) begin
            p = (s == 7) ? 3'b100 : 3'b000;
            step_chk($sformatf("t5 s%0d", s), 3'b100,
                     (s >= 7) ? 3'b100 : 3'b000, p,
                     (s == 7 || (RPT && (s == 15 || s == 23))) ? 3'b100 : 3'b000);
        end
        release_chk("t5", 3'b100, 1);

        // 6) Reset while lane 1 sits in WQ with cnt=2 (after step 5): the
        //    lane aborts and must re-qualify from scratch after Reset drops.
        for (int s = 1; s <= 5; s++)
            step_chk($sformatf("t6 s%0d", s), 3'b010, 3'b000, 3'b000, 3'b000);
        Reset = 1'b1;
        step_chk("t6 rst", 3'b010, 3'b000, 3'b000, 3'b000);
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            p = (k == 7) ? 3'b010 : 3'b000;
            step_chk($sformatf("t6 k%0d", k), 3'b010,
                     (k >= 7) ? 3'b010 : 3'b000, p, p);
        end
        release_chk("t6", 3'b010, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wwm_btn_conditioner.md
Name: wwm_btn_conditioner

Overview:
- Upstream input-conditioning stage between the raw Nexys4 push-buttons and wwm_sm.
- Per-button path: 2-FF synchronizer, counter-based debounce FSM, then one-clock press pulses (Start, Fire, Ack).
- Removes contact bounce and metastability so that one physical press gives exactly one state-machine event.
- Optional auto-repeat pulse stream for holding a button.

Parameters:
- N_BTN, 3, number of independent button lanes (bit 0 = BtnU/Start, bit 1 = BtnR/Fire, bit 2 = Ack source).
- DB_CYCLES, 1000000, stable-level clock count needed to accept a press or release (10 ms at 100 MHz); legal range ≥ 2.
- RPT_CYCLES, 25000000, auto-repeat period in clocks while held (250 ms); legal range ≥ 2.
- CNT_W, 25, counter width; must satisfy 2^CNT_W > max(DB_CYCLES, RPT_CYCLES).

Ports:
- clk  in  1  board clock (ClkPort).
- Reset  in  1  synchronous, active-high reset.
- btn_in  in  N_BTN  raw asynchronous button levels, active-high.
- btn_db  out  N_BTN  debounced level.
- btn_scen  out  N_BTN  single-clock pulse per accepted press.
- btn_mcen  out  N_BTN  press pulse plus auto-repeat pulses.
- Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on any clk edge with Reset=1, sync FFs, counters and all lane FSMs clear to INI; btn_db, btn_scen and btn_mcen are 0 from that edge. Reset mid-press aborts the lane; a button still held after Reset deasserts must be fully re-debounced.
- Lanes are fully independent; simultaneous presses on several lanes give same-cycle pulses.
- Synchronizer: s1 <= btn_in, s2 <= s1. The FSM uses only s2.
- Per-lane FSM states and transitions (all outputs registered Moore):
  - INI: db=0. If s2=1, go to WQ with cnt=0.
  - WQ (press qualify): cnt increments each clock. s2=0 returns to INI. cnt==DB_CYCLES-1 with s2=1 goes to SCEN_ST.
  - SCEN_ST: exactly 1 cycle; db=1, scen=1, mcen=1. Then go to HOLD with rcnt=0.
  - HOLD: db=1. s2=0 goes to WFR with cnt=0. Otherwise rcnt increments (repeat behaviour: see Optional Feature).
  - WFR (release qualify): db=1; cnt increments. s2=1 returns to HOLD, cnt cleared, rcnt kept. cnt==DB_CYCLES-1 with s2=0 goes to INI; db falls on that transition.
- Press latency: btn_in sampled high at edge E, held stable. btn_scen is high for the single cycle following edge E+DB_CYCLES+2 (2 sync edges + entry to WQ + DB_CYCLES-1 counts + transition). btn_db rises in that same cycle.
- Release latency: btn_db falls DB_CYCLES+2 edges after btn_in is sampled low.
- Glitch rejection: a high pulse shorter than DB_CYCLES+1 clocks after sync produces no output. A low glitch during HOLD shorter than DB_CYCLES produces no release and no second btn_scen.
- btn_scen is at most one pulse per accepted press, never back-to-back.
- Counters saturate at no point: each is cleared on every state entry, and the compare value is always less than 2^CNT_W.

Optional Feature:
- Macro: WWM_BTN_REPEAT_EN.
- Defined: in HOLD, when rcnt==RPT_CYCLES-1, the lane pulses btn_mcen for 1 cycle and clears rcnt, staying in HOLD. Pulses therefore come every RPT_CYCLES clocks after the SCEN_ST cycle while the button is held. Repeat pulses continue during WFR bounce.
- Undefined: the rcnt logic is removed; btn_mcen is identical to btn_scen.

Test Plan (DB_CYCLES=4, RPT_CYCLES=8, N_BTN=3):
- Reset held 3 cycles with btn_in=3'b111 → all outputs 0 during reset. After release, btn_scen=3'b111 for one cycle 6 edges later, and btn_db=3'b111.
- btn_in[0] high for 3 clocks then low → btn_scen, btn_mcen and btn_db stay 0 throughout.
- btn_in[1] bounces 1010 1100 then stays high 20 clocks → exactly one btn_scen[1] pulse, 6 edges after the last rising sample. btn_db[1] falls 6 edges after btn_in[1] goes low.
- Held press with a 2-clock low glitch in HOLD → no btn_db drop and no second btn_scen.
- WWM_BTN_REPEAT_EN defined, btn_in[2] held 30 clocks → btn_mcen[2] pulses at the SCEN_ST cycle, then +8 and +16 clocks, and again while held; btn_scen[2] pulses once. Macro undefined: btn_mcen[2] == btn_scen[2].
- Reset asserted while lane 1 is in WQ (cnt=2) → lane returns to INI. With the button still held, a new btn_scen arrives 6 edges after Reset deasserts.
